tb_lights_seq: RTL and testbench
================================

Name: tb_lights_seq

Overview:
- Parametrised successor to the three-lamp Thunderbird tail-light sequencer.
- Drives N_LAMPS lamps per side with sequential left and right turn chases, a hazard flash and a brake overlay.
- An internal prescaler sets the chase rate, so the block runs directly off the system clock.
- Sits between the driver-input synchroniser and the lamp driver stage.

Parameters:
- N_LAMPS, 3, lamps per side; legal range 1 or more.
- TICK_DIV, 4, system clocks per animation step; legal range 1 or more (1 = step every clock).
- PW, $clog2(N_LAMPS+1), derived; width of the step position. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- L  in  1  left-turn request (synchronous to clk).
- R  in  1  right-turn request.
- H  in  1  hazard request.
- B  in  1  brake request.
- lamp_l  out  N_LAMPS  left lamps; bit 0 is the innermost lamp (old LA), bit N_LAMPS-1 the outermost.
- lamp_r  out  N_LAMPS  right lamps; bit 0 innermost (old RA).
- seq_done  out  1  one-clock pulse when a turn chase wraps from all-on back to all-off.

Behaviour:
- Reset: clear low forces, immediately and asynchronously, cnt=0, mode=IDLE, pos=0, lamp_l=0, lamp_r=0, seq_done=0. Reset can assert at any point mid-sequence.
- Prescaler: cnt counts 0..TICK_DIV-1 and wraps. tick=1 exactly when cnt==TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Request decode, by priority:
  - H=1, or L&R=1 -> HAZ.
  - else L -> LEFT.
  - else R -> RIGHT.
  - else IDLE.
- Request sampling: requests are sampled only on tick edges. Requests that appear and clear between ticks are ignored.
- State update on a tick edge:
  - If req != mode: mode<=req, pos<=0. A chase is aborted to the all-off frame with no partial completion.
  - Else if mode is LEFT or RIGHT: pos<=(pos==N_LAMPS) ? 0 : pos+1.
  - Else if mode is HAZ: pos<=pos^1 (only values 0 and 1 are used).
  - Else if mode is IDLE: pos<=0.
- Non-tick edges: mode and pos hold.
- seq_done: registered. Set to 1 on the tick edge where a LEFT/RIGHT mode is unchanged and pos goes N_LAMPS->0; 0 on every other edge.
- Lamp pattern from (mode, pos):
  - Turn side: lamp[i] = (i < pos). For N=3 the frames are 000,001,011,111,000,...
  - HAZ: both sides all-ones when pos=1, all-zeros when pos=0.
- Brake overlay:
  - B=1 sets every non-turning side to all-ones: both sides in IDLE, the right side in LEFT, the left side in RIGHT.
  - B is ignored in HAZ.
  - The turning side is never overridden by B.
- Output timing:
  - lamp_l and lamp_r are registered and updated on every clk edge from next-state mode/pos and the current B.
  - A state change and its lamp pattern appear on the same edge.
  - B reaches the lamps one edge after it is sampled, independent of tick.
- Reset mid-operation: the sequence restarts from IDLE/pos=0 and the prescaler from cnt=0. The first tick after release occurs TICK_DIV edges later.

Decomposition:
- Package tb_lights_pkg:
  - mode enum: IDLE, LEFT, RIGHT, HAZ.
  - pure function fill_mask(pos) returning an N_LAMPS-bit thermometer code.
  - request-priority function.
- Sub-module tb_tick_gen: prescaler with parameter TICK_DIV, ports clk, clear, tick.
- Main module: mode/pos FSM, seq_done and output registers.

Test Plan:
- Reset with clear=0, then release with L=R=H=B=0 -> lamp_l=lamp_r=000, seq_done=0, and outputs held over 40 clocks.
- N=3, TICK_DIV=4, hold L=1 -> on successive ticks lamp_l=000 (mode switch), 001, 011, 111, 000. seq_done pulses for one clock on the 111->000 tick. lamp_r stays 000 throughout.
- R=1 with B=1 -> lamp_r chases 001,011,111,000 and lamp_l=111 constant. Drop B -> lamp_l=000 one clock later, with no tick needed.
- Chase at lamp_l=011, then assert H -> next tick both sides 000, then 111/000 alternating per tick. Set L=R=1 with H=0 -> hazard pattern unchanged.
- Mid-chase at 011, pulse clear low for 1 clock -> all outputs 0 immediately. With L still high, the first step 000->001 comes two ticks after release (first tick = mode switch).
- Generic override N_LAMPS=5, TICK_DIV=1 with L=1 -> lamp_l steps 00000,00001,...,11111,00000 on consecutive clocks, and seq_done has a period of 6 clocks.

Source files
------------

// File: rtl/tb_lights_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// Mode encoding, thermometer fill and request priority.
package tb_lights_pkg;

   localparam int MAX_LAMPS = 64;

   typedef enum logic [1:0] {
      IDLE,
      LEFT,
      RIGHT,
      HAZ
   } mode_t;

   typedef logic [MAX_LAMPS-1:0] mask_t;

   function automatic mask_t fill_mask(input logic [31:0] pos);
      mask_t m;
      m = '0;
      for (int unsigned i = 0; i < MAX_LAMPS; i++)
         m[i] = (i < pos);
      return m;
   endfunction

   function automatic mode_t decode_req(input logic l,
                                        input logic r,
                                        input logic h);
      mode_t q;
      if (h || (l && r))
         q = HAZ;
      else if (l)
         q = LEFT;
      else if (r)
         q = RIGHT;
      else
         q = IDLE;
      return q;
   endfunction

endpackage

// File: rtl/tb_tick_gen.sv
// Animation-rate prescaler.
// tick is high on the last count of each TICK_DIV-clock period.
module tb_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/tb_lights_seq.sv
// Parametrised tail-light sequencer: turn chases, hazard, brake.
// Lamps are registered from next-state mode/pos and current B.
module tb_lights_seq
   import tb_lights_pkg::*;
#(
   parameter  int N_LAMPS  = 3,
   parameter  int TICK_DIV = 4,
   localparam int PW       = $clog2(N_LAMPS + 1)
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               L,
   input  logic               R,
   input  logic               H,
   input  logic               B,
   output logic [N_LAMPS-1:0] lamp_l,
   output logic [N_LAMPS-1:0] lamp_r,
   output logic               seq_done
);

   localparam logic [PW-1:0] LAST = PW'(N_LAMPS);

   logic               tick;
   mode_t              mode;
   mode_t              nmode;
   mode_t              req;
   logic [PW-1:0]      pos;
   logic [PW-1:0]      npos;
   logic               ndone;
   logic [N_LAMPS-1:0] thermo;
   logic [N_LAMPS-1:0] fill;
   logic [N_LAMPS-1:0] nl;
   logic [N_LAMPS-1:0] nr;

   tb_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .clear(clear),
      .tick (tick)
   );

   always_comb begin
      nmode = mode;
      npos  = pos;
      ndone = 1'b0;
      req   = decode_req(L, R, H);
      if (tick) begin
         if (req != mode) begin
            nmode = req;
            npos  = '0;
         end else begin
            unique case (mode)
               LEFT, RIGHT: begin
                  if (pos == LAST) begin
                     npos  = '0;
                     ndone = 1'b1;
                  end else begin
                     npos = pos + PW'(1);
                  end
               end
               HAZ:     npos = pos ^ PW'(1);
               default: npos = '0;
            endcase
         end
      end
   end

   // Brake lights every side that is not chasing; hazard ignores it.
   always_comb begin
      thermo = N_LAMPS'(fill_mask(32'(npos)));
      fill   = {N_LAMPS{B}};
      nl     = '0;
      nr     = '0;
      unique case (nmode)
         IDLE: begin
            nl = fill;
            nr = fill;
         end
         LEFT: begin
            nl = thermo;
            nr = fill;
         end
         RIGHT: begin
            nl = fill;
            nr = thermo;
         end
         HAZ: begin
            nl = {N_LAMPS{npos[0]}};
            nr = {N_LAMPS{npos[0]}};
         end
         default: begin
            nl = '0;
            nr = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         mode     <= IDLE;
         pos      <= '0;
         lamp_l   <= '0;
         lamp_r   <= '0;
         seq_done <= 1'b0;
      end else begin
         mode     <= nmode;
         pos      <= npos;
         lamp_l   <= nl;
         lamp_r   <= nr;
         seq_done <= ndone;
      end
   end

endmodule

// File: tb/tb_tb_lights_seq.sv
// Bench for tb_lights_seq: default 3-lamp/div-4 and 5-lamp/div-1
// instances checked each cycle against an arithmetic model.
module tb_tb_lights_seq;

   logic       clk;
   logic       clear;
   logic       L;
   logic       R;
   logic       H;
   logic       B;
   logic [2:0] l3;
   logic [2:0] r3;
   logic       d3;
   logic [4:0] l5;
   logic [4:0] r5;
   logic       d5;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   int nn[2] = '{3, 5};
   int td[2] = '{4, 1};

   // model: 0 idle, 1 left, 2 right, 3 hazard
   int          mm[2];
   int          ms[2];
   int          mk[2];
   logic [31:0] ml[2];
   logic [31:0] mr[2];
   logic        md[2];

   tb_lights_seq u_d3 (
      .clk     (clk),
      .clear   (clear),
      .L       (L),
      .R       (R),
      .H       (H),
      .B       (B),
      .lamp_l  (l3),
      .lamp_r  (r3),
      .seq_done(d3)
   );

   tb_lights_seq #(
      .N_LAMPS (5),
      .TICK_DIV(1)
   ) u_d5 (
      .clk     (clk),
      .clear   (clear),
      .L       (L),
      .R       (R),
      .H       (H),
      .B       (B),
      .lamp_l  (l5),
      .lamp_r  (r5),
      .seq_done(d5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at cyc %0d",
                  nm, act, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mm[i] = 0;
         ms[i] = 0;
         mk[i] = 0;
         ml[i] = 0;
         mr[i] = 0;
         md[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i);
      int req;
      int all;
      int th;
      int bf;
      mk[i]++;
      md[i] = 1'b0;
      if (mk[i] % td[i] == 0) begin
         if (H || (L && R)) req = 3;
         else if (L)        req = 1;
         else if (R)        req = 2;
         else               req = 0;
         if (req != mm[i]) begin
            mm[i] = req;
            ms[i] = 0;
         end else if (mm[i] == 1 || mm[i] == 2) begin
            if (ms[i] == nn[i]) begin
               ms[i] = 0;
               md[i] = 1'b1;
            end else begin
               ms[i]++;
            end
         end else if (mm[i] == 3) begin
            ms[i] = 1 - ms[i];
         end else begin
            ms[i] = 0;
         end
      end
      all = (1 << nn[i]) - 1;
      th  = (1 << ms[i]) - 1;
      bf  = B ? all : 0;
      case (mm[i])
         0: begin ml[i] = bf; mr[i] = bf; end
         1: begin ml[i] = th; mr[i] = bf; end
         2: begin ml[i] = bf; mr[i] = th; end
         default: begin
            ml[i] = ms[i] != 0 ? all : 0;
            mr[i] = ml[i];
         end
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      if (clear) begin
         cyc_n++;
         model_edge(0);
         model_edge(1);
      end
      @(negedge clk);
      chk("l3", 32'(l3), ml[0]);
      chk("r3", 32'(r3), mr[0]);
      chk("d3", 32'(d3), 32'(md[0]));
      chk("l5", 32'(l5), ml[1]);
      chk("r5", 32'(r5), mr[1]);
      chk("d5", 32'(d5), 32'(md[1]));
   endtask

   task automatic wait_step2();
      int n;
      n = 0;
      while (!(mm[0] == 1 && ms[0] == 2) && n < 40) begin
         cyc();
         n++;
      end
      chk("reach_011", 32'(l3), 32'd3);
   endtask

   initial begin
      clear = 1'b0;
      L = 0; R = 0; H = 0; B = 0;
      model_reset();
      #3;
      chk("rst_l3", 32'(l3), 0);
      chk("rst_r3", 32'(r3), 0);
      chk("rst_d3", 32'(d3), 0);
      chk("rst_l5", 32'(l5), 0);
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      repeat (40) cyc();
      chk("idle_l3", 32'(l3), 0);
      chk("idle_r3", 32'(r3), 0);

      L = 1;
      repeat (21) begin
         cyc();
         case (cyc_n)
            42: chk("c5_1", 32'(l5), 32'd1);
            44: chk("l3_switch", 32'(l3), 32'd0);
            46: chk("c5_31", 32'(l5), 32'd31);
            47: chk("c5_done", 32'(d5), 32'd1);
            48: chk("l3_001", 32'(l3), 32'd1);
            52: chk("l3_011", 32'(l3), 32'd3);
            53: chk("c5_done6", 32'(d5), 32'd1);
            56: chk("l3_111", 32'(l3), 32'd7);
            60: begin
               chk("l3_wrap", 32'(l3), 32'd0);
               chk("d3_pulse", 32'(d3), 32'd1);
               chk("r3_off", 32'(r3), 32'd0);
            end
            61: chk("d3_1clk", 32'(d3), 32'd0);
            default: ;
         endcase
      end

      L = 0; R = 1; B = 1;
      repeat (24) cyc();
      chk("brake_l3", 32'(l3), 32'd7);
      B = 0;
      cyc();
      chk("brake_drop", 32'(l3), 32'd0);

      R = 0; L = 1;
      wait_step2();
      H = 1;
      repeat (4) cyc();
      chk("haz0_l", 32'(l3), 32'd0);
      chk("haz0_r", 32'(r3), 32'd0);
      repeat (4) cyc();
      chk("haz1_l", 32'(l3), 32'd7);
      chk("haz1_r", 32'(r3), 32'd7);
      H = 0; L = 1; R = 1;
      repeat (4) cyc();
      chk("lr_haz0", 32'(l3), 32'd0);
      repeat (4) cyc();
      chk("lr_haz1", 32'(r3), 32'd7);

      R = 0;
      wait_step2();
      clear = 1'b0;
      #1;
      chk("arst_l3", 32'(l3), 0);
      chk("arst_d3", 32'(d3), 0);
      chk("arst_l5", 32'(l5), 0);
      model_reset();
      cyc_n = 0;
      @(negedge clk);
      clear = 1'b1;
      repeat (8) begin
         cyc();
         case (cyc_n)
            2: chk("rel_c5", 32'(l5), 32'd1);
            4: chk("rel_sw", 32'(l3), 32'd0);
            7: chk("rel_hold", 32'(l3), 32'd0);
            8: chk("rel_001", 32'(l3), 32'd1);
            default: ;
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
